// File: rtl/pp_row_serializer.sv
// Serializes the AND partial-product rows of a W x W multiply, ROWS rows per beat,
// over valid/ready handshakes; operands are captured once and replayed from registers.
module pp_row_serializer #(
    parameter int W    = 53,
    parameter int ROWS = 4,
    localparam int BEATS = (W + ROWS - 1) / ROWS,
    localparam int IW    = ($clog2(BEATS * ROWS) < 1) ? 1 : $clog2(BEATS * ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROWS*W-1:0] out_rows,
    output logic [IW-1:0]     out_row_idx,
    output logic              out_last,
    output logic              out_zero
);

    localparam int BP       = BEATS * ROWS;
    localparam int LAST_IDX = (BEATS - 1) * ROWS;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [W-1:0]      a_q, b_q;
    logic [W-1:0]      sel_a, sel_b;
    logic [BP-1:0]     b_pad;
    logic [IW-1:0]     nxt_idx;
    logic [ROWS*W-1:0] nxt_rows;

    assign in_ready = (state == IDLE);

    // The beat being loaded comes from the live inputs on capture, otherwise from
    // the held operands; zero-padding b makes rows past W come out all-zero.
    always_comb begin
        sel_a   = a_q;
        sel_b   = b_q;
        nxt_idx = out_row_idx + IW'(ROWS);
        if (state == IDLE) begin
            sel_a   = a;
            sel_b   = b;
            nxt_idx = '0;
        end
        b_pad = BP'(sel_b);
    end

    for (genvar j = 0; j < ROWS; j++) begin : g_slot
        logic [IW-1:0] row_idx;
        assign row_idx = nxt_idx + IW'(j);
        assign nxt_rows[j*W +: W] = b_pad[row_idx] ? sel_a : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            out_valid   <= 1'b0;
            out_rows    <= '0;
            out_row_idx <= '0;
            out_last    <= 1'b0;
            out_zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q         <= a;
                        b_q         <= b;
                        out_valid   <= 1'b1;
                        out_rows    <= nxt_rows;
                        out_row_idx <= nxt_idx;
                        out_last    <= (nxt_idx == IW'(LAST_IDX));
                        out_zero    <= ~|nxt_rows;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            out_rows    <= nxt_rows;
                            out_row_idx <= nxt_idx;
                            out_last    <= (nxt_idx == IW'(LAST_IDX));
                            out_zero    <= ~|nxt_rows;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
